brc_resolve: RTL and testbench



---
 rtl/brc_pkg.sv | 42 ++++
 rtl/brc_cmp.sv | 37 +++
 rtl/brc_resolve.sv | 133 +++++++++++++
 tb/tb_brc_resolve.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// brc_pkg
//   Shared definitions for the branch resolution unit and its comparator.
//   Defines the RISC-V branch funct3 encodings, the two reserved
//   (illegal) funct3 codes, and small helpers that turn raw compare flags
//   into a branch decision.
package brc_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_op_e;

  // funct3 values with no branch meaning in the base ISA
  localparam logic [2:0] BR_ILL0 = 3'b010;
  localparam logic [2:0] BR_ILL1 = 3'b011;

  function automatic logic is_illegal(input logic [2:0] funct3);
    return (funct3 == BR_ILL0) || (funct3 == BR_ILL1);
  endfunction

  // Illegal codes resolve as not-taken so the mispredict flag simply
  // mirrors the prediction for them.
  function automatic logic resolve_taken(input logic [2:0] funct3,
                                         input logic       less,
                                         input logic       equal);
    logic taken;
    taken = 1'b0;
    case (funct3)
      BR_BEQ:           taken = equal;
      BR_BNE:           taken = !equal;
      BR_BLT, BR_BLTU:  taken = less;
      BR_BGE, BR_BGEU:  taken = !less;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/brc_cmp.sv
// brc_cmp
//   Combinational magnitude/equality compare of two WIDTH-bit operands,
//   signed or unsigned. Shared with the ALU set-less-than path.
// Ports:
//   a, b        operands
//   is_unsigned 1 = unsigned compare, 0 = signed compare
//   less        a < b under the selected interpretation
//   equal       a == b
module brc_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             less,
  output logic             equal
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] diff;

  // One extra bit makes the subtraction exact for both signed and
  // unsigned operands, so the top bit of the difference is the true sign
  // even at the extremes (min signed vs max signed, all ones unsigned).
  always_comb begin
    ext_a = {a[WIDTH-1] & ~is_unsigned, a};
    ext_b = {b[WIDTH-1] & ~is_unsigned, b};
    diff  = ext_a + ~ext_b + {{WIDTH{1'b0}}, 1'b1};
  end

  assign less = diff[WIDTH];
  // The exact difference can only be zero when the operands match, so this
  // is the same as a == b while reusing the subtractor.
  assign equal = (diff == '0);

endmodule

// File: rtl/brc_resolve.sv
// brc_resolve
//   Two-stage pipelined branch resolver. Stage 1 captures the operands,
//   funct3, prediction and tag; stage 2 captures the compare result, the
//   resolved direction and the mispredict flag. Valid/ready on both sides,
//   no skid buffer, so o_ready is combinational from i_ready.
// Ports:
//   i_clk, i_rst       clock and synchronous active-high reset
//   i_flush            drop everything in flight (and any input this cycle)
//   i_valid/o_ready    upstream handshake
//   i_rs1_data/i_rs2_data/i_funct3/i_pred_taken/i_tag  request payload
//   o_valid/i_ready    downstream handshake
//   o_taken/o_mispredict/o_illegal/o_less/o_equal/o_tag  result payload
// WIDTH must be at least 2.
module brc_resolve
  import brc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [2:0]       i_funct3,
  input  logic             i_pred_taken,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_illegal,
  output logic             o_less,
  output logic             o_equal,
  output logic [TAG_W-1:0] o_tag
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_funct3;
  logic             s1_pred;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic             s2_taken;
  logic             s2_mispredict;
  logic             s2_illegal;
  logic             s2_less;
  logic             s2_equal;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic             cmp_less;
  logic             cmp_equal;
  logic             s1_taken;
  logic             s1_illegal;

  // Stage 2 takes the stage 1 entry whenever it is empty or being drained;
  // stage 1 can take a new request whenever it is empty or moving on.
  assign s2_load = s1_valid && (!s2_valid || i_ready);
  assign o_ready = !s1_valid || s2_load;

  // funct3[1] separates the unsigned forms (BLTU/BGEU) from the signed ones
  brc_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a           (s1_a),
    .b           (s1_b),
    .is_unsigned (s1_funct3[1]),
    .less        (cmp_less),
    .equal       (cmp_equal)
  );

  assign s1_taken   = resolve_taken(s1_funct3, cmp_less, cmp_equal);
  assign s1_illegal = is_illegal(s1_funct3);

  // Stage 1 occupancy; flush and reset win over any incoming request.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      s1_valid <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
    end
  end

  // Stage 1 payload has no reset; it is only meaningful under s1_valid.
  always_ff @(posedge i_clk) begin
    if (i_valid && o_ready) begin
      s1_a      <= i_rs1_data;
      s1_b      <= i_rs2_data;
      s1_funct3 <= i_funct3;
      s1_pred   <= i_pred_taken;
      s1_tag    <= i_tag;
    end
  end

  // Stage 2 drives the outputs directly, so its payload is cleared on
  // reset and otherwise only changes on a load, which keeps it stable
  // while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid      <= 1'b0;
      s2_taken      <= 1'b0;
      s2_mispredict <= 1'b0;
      s2_illegal    <= 1'b0;
      s2_less       <= 1'b0;
      s2_equal      <= 1'b0;
      s2_tag        <= '0;
    end else if (i_flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid      <= 1'b1;
      s2_taken      <= s1_taken;
      s2_mispredict <= s1_taken ^ s1_pred;
      s2_illegal    <= s1_illegal;
      s2_less       <= cmp_less;
      s2_equal      <= cmp_equal;
      s2_tag        <= s1_tag;
    end else if (i_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign o_valid      = s2_valid;
  assign o_taken      = s2_taken;
  assign o_mispredict = s2_mispredict;
  assign o_illegal    = s2_illegal;
  assign o_less       = s2_less;
  assign o_equal      = s2_equal;
  assign o_tag        = s2_tag;

endmodule

// File: tb/tb_brc_resolve.sv
// tb_brc_resolve
//   Bench for brc_resolve with default parameters. A reference model holds
//   the in-flight branches as a queue of expected results, each tagged with
//   the earliest sample cycle at which it may appear, and is compared with
//   the DUT outputs at every falling edge. Directed scenarios add literal
//   expectations; a randomized phase follows.
module tb_brc_resolve;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [2:0]       funct3;
  logic             pred_taken;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             down_ready;
  logic             taken;
  logic             mispredict;
  logic             illegal;
  logic             less;
  logic             equal;
  logic [TAG_W-1:0] out_tag;

  int n_vectors     = 0;
  int n_miscompares = 0;

  brc_resolve #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_valid      (in_valid),
    .o_ready      (in_ready),
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .i_funct3     (funct3),
    .i_pred_taken (pred_taken),
    .i_tag        (tag),
    .o_valid      (out_valid),
    .i_ready      (down_ready),
    .o_taken      (taken),
    .o_mispredict (mispredict),
    .o_illegal    (illegal),
    .o_less       (less),
    .o_equal      (equal),
    .o_tag        (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    bit               taken;
    bit               mis;
    bit               ill;
    bit               less;
    bit               eq;
    int               vis;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  bit   armed = 0;
  bit   mv;
  bit   mr;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Branch semantics straight from the ISA definition
  function automatic exp_t expectFor(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] f3, input bit pred,
                                     input logic [TAG_W-1:0] t);
    exp_t e;
    e.tag  = t;
    e.eq   = (a == b);
    e.less = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    e.ill  = 0;
    case (f3)
      3'b000:  e.taken = e.eq;
      3'b001:  e.taken = !e.eq;
      3'b100:  e.taken = e.less;
      3'b101:  e.taken = !e.less;
      3'b110:  e.taken = e.less;
      3'b111:  e.taken = !e.less;
      default: begin e.taken = 0; e.ill = 1; end
    endcase
    e.mis = (e.taken != pred);
    e.vis = 0;
    return e;
  endfunction

  // The pipe holds at most two branches. A branch accepted in sample cycle
  // k shows up at cycle k+2 at the earliest, and never before the cycle
  // after the branch ahead of it left.
  always @(negedge clk) begin
    mv = (q.size() > 0) && (q[0].vis <= cyc);
    mr = !((q.size() == 2) && !down_ready);
    if (armed) begin
      checkOutput("o_valid", 64'(out_valid), 64'(mv));
      checkOutput("o_ready", 64'(in_ready), 64'(mr));
      if (mv) begin
        checkOutput("o_tag", 64'(out_tag), 64'(q[0].tag));
        checkOutput("o_taken", 64'(taken), 64'(q[0].taken));
        checkOutput("o_mispredict", 64'(mispredict), 64'(q[0].mis));
        checkOutput("o_illegal", 64'(illegal), 64'(q[0].ill));
        checkOutput("o_less", 64'(less), 64'(q[0].less));
        checkOutput("o_equal", 64'(equal), 64'(q[0].eq));
      end
    end
    if (rst) begin
      q.delete();
      armed = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (mv && down_ready) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
      end
      if (in_valid && mr) begin
        exp_t e;
        e = expectFor(rs1_data, rs2_data, funct3, pred_taken, tag);
        e.vis = cyc + 2;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] f3, input bit pred, input logic [TAG_W-1:0] t,
                               input bit rdy, input bit fl, input bit rs);
    @(posedge clk);
    #1;
    in_valid   = v;
    rs1_data   = a;
    rs2_data   = b;
    funct3     = f3;
    pred_taken = pred;
    tag        = t;
    down_ready = rdy;
    flush      = fl;
    rst        = rs;
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(0, '0, '0, 3'b000, 0, '0, rdy, 0, 0);
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; flush = 0; in_valid = 0; down_ready = 1;
    rs1_data = '0; rs2_data = '0; funct3 = '0; pred_taken = 0; tag = '0;
    applyStimulus(0, '0, '0, 3'b000, 0, '0, 1, 0, 1);
    applyStimulus(0, '0, '0, 3'b000, 0, '0, 1, 0, 1);
    idle(1);
    waitSample();
    $display("[TB] reset state");
    checkOutput("reset o_valid", 64'(out_valid), 64'd0);
    checkOutput("reset o_ready", 64'(in_ready), 64'd1);
    checkOutput("reset o_taken", 64'(taken), 64'd0);
    checkOutput("reset o_tag", 64'(out_tag), 64'd0);

    $display("[TB] BLT / BLTU with -1 vs 1");
    applyStimulus(1, 32'hFFFF_FFFF, 32'h1, 3'b100, 0, 5'd1, 1, 0, 0);
    idle(1); idle(1);
    waitSample();
    checkOutput("blt o_valid", 64'(out_valid), 64'd1);
    checkOutput("blt o_taken", 64'(taken), 64'd1);
    checkOutput("blt o_mispredict", 64'(mispredict), 64'd1);
    checkOutput("blt o_less", 64'(less), 64'd1);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h1, 3'b110, 0, 5'd2, 1, 0, 0);
    idle(1); idle(1);
    waitSample();
    checkOutput("bltu o_tag", 64'(out_tag), 64'd2);
    checkOutput("bltu o_taken", 64'(taken), 64'd0);
    checkOutput("bltu o_mispredict", 64'(mispredict), 64'd0);

    $display("[TB] illegal funct3 and BEQ on min signed");
    applyStimulus(1, 32'h1234_5678, 32'h9, 3'b010, 1, 5'd3, 1, 0, 0);
    idle(1); idle(1);
    waitSample();
    checkOutput("ill o_illegal", 64'(illegal), 64'd1);
    checkOutput("ill o_taken", 64'(taken), 64'd0);
    checkOutput("ill o_mispredict", 64'(mispredict), 64'd1);
    applyStimulus(1, 32'h8000_0000, 32'h8000_0000, 3'b000, 0, 5'd4, 1, 0, 0);
    idle(1); idle(1);
    waitSample();
    checkOutput("beq o_equal", 64'(equal), 64'd1);
    checkOutput("beq o_taken", 64'(taken), 64'd1);
    idle(1); idle(1);

    $display("[TB] back-to-back stream of 8");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, $urandom, $urandom, 3'b101, i[0], 5'(i), 1, 0, 0);
      waitSample();
      checkOutput("stream o_ready", 64'(in_ready), 64'd1);
      if (i >= 2) checkOutput("stream o_tag", 64'(out_tag), 64'(i - 2));
    end
    for (int i = 6; i < 8; i++) begin
      idle(1);
      waitSample();
      checkOutput("stream tail o_valid", 64'(out_valid), 64'd1);
      checkOutput("stream tail o_tag", 64'(out_tag), 64'(i));
    end
    idle(1);
    waitSample();
    checkOutput("stream drained", 64'(out_valid), 64'd0);

    $display("[TB] fill and stall");
    applyStimulus(1, 32'd5, 32'd5, 3'b000, 1, 5'd10, 0, 0, 0);
    waitSample();
    checkOutput("fill1 o_ready", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'd3, 32'd7, 3'b110, 1, 5'd11, 0, 0, 0);
    waitSample();
    checkOutput("fill2 o_ready", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'd1, 32'd2, 3'b100, 0, 5'd12, 0, 0, 0);
    waitSample();
    checkOutput("full o_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      waitSample();
      checkOutput("hold o_valid", 64'(out_valid), 64'd1);
      checkOutput("hold o_tag", 64'(out_tag), 64'd10);
      checkOutput("hold o_taken", 64'(taken), 64'd1);
    end
    idle(1);
    waitSample();
    checkOutput("release first tag", 64'(out_tag), 64'd10);
    idle(1);
    waitSample();
    checkOutput("release second tag", 64'(out_tag), 64'd11);
    checkOutput("release second taken", 64'(taken), 64'd1);
    idle(1);
    waitSample();
    checkOutput("release drained", 64'(out_valid), 64'd0);

    $display("[TB] flush with full pipe");
    applyStimulus(1, 32'd1, 32'd1, 3'b000, 0, 5'd20, 0, 0, 0);
    applyStimulus(1, 32'd1, 32'd2, 3'b001, 0, 5'd21, 0, 0, 0);
    applyStimulus(1, 32'd4, 32'd2, 3'b101, 0, 5'd22, 0, 1, 0);
    waitSample();
    checkOutput("pre-flush o_valid", 64'(out_valid), 64'd1);
    idle(1);
    waitSample();
    checkOutput("flush o_valid", 64'(out_valid), 64'd0);
    checkOutput("flush o_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      waitSample();
      checkOutput("no stale result", 64'(out_valid), 64'd0);
    end

    $display("[TB] reset during stall");
    applyStimulus(1, 32'd9, 32'd9, 3'b000, 0, 5'd30, 0, 0, 0);
    applyStimulus(1, 32'd9, 32'd8, 3'b001, 0, 5'd31, 0, 0, 0);
    idle(0);
    waitSample();
    checkOutput("stall o_valid", 64'(out_valid), 64'd1);
    checkOutput("stall o_taken", 64'(taken), 64'd1);
    applyStimulus(0, '0, '0, 3'b000, 0, '0, 0, 0, 1);
    idle(0);
    waitSample();
    checkOutput("post-reset o_valid", 64'(out_valid), 64'd0);
    checkOutput("post-reset o_taken", 64'(taken), 64'd0);
    checkOutput("post-reset o_ready", 64'(in_ready), 64'd1);
    idle(1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = pickOperand();
      b = ($urandom_range(0, 3) == 0) ? a : pickOperand();
      applyStimulus($urandom_range(0, 9) < 7, a, b, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1);
    waitSample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
